// File: rtl/sw_pe_affine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sw_pe_affine_pkg
// Purpose  : Shared constants, traceback encodings and saturating adder for
//            the affine-gap Smith-Waterman processing element.
// Revision : 1.0 - initial release
// ============================================================================
package sw_pe_affine_pkg;

    // Working width for the width-generic helpers; score widths up to 31 bits.
    localparam int MAX_W = 32;

    localparam logic [1:0] DIR_ZERO = 2'b00;
    localparam logic [1:0] DIR_DIAG = 2'b01;
    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_LEFT = 2'b11;

    function automatic logic signed [MAX_W-1:0] neg_inf(input int w);
        return $signed({MAX_W{1'b1}} << (w - 1));
    endfunction

    function automatic logic signed [MAX_W-1:0] pos_max(input int w);
        return ~neg_inf(w);
    endfunction

    // Operands arrive sign-extended to MAX_W; result is clamped to a w-bit range.
    function automatic logic signed [MAX_W-1:0] sat_add(
        input logic signed [MAX_W-1:0] a,
        input logic signed [MAX_W-1:0] b,
        input int                      w
    );
        logic signed [MAX_W:0] sum;
        logic signed [MAX_W:0] lo;
        logic signed [MAX_W:0] hi;
        sum = {a[MAX_W-1], a} + {b[MAX_W-1], b};
        lo  = (MAX_W+1)'(neg_inf(w));
        hi  = (MAX_W+1)'(pos_max(w));
        if (sum < lo) return neg_inf(w);
        if (sum > hi) return pos_max(w);
        return sum[MAX_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_pe_affine_max3_dir.sv
`default_nettype none
// ============================================================================
// Module   : sw_max3_dir
// Purpose  : Three-way max of D/F/E with D>F>E tie priority, optional local
//            clamp at zero and traceback direction code.
// Revision : 1.0 - initial release
// ============================================================================
module sw_max3_dir
    import sw_pe_affine_pkg::*;
#(
    parameter int SCORE_W = 16
) (
    input  logic signed [SCORE_W-1:0] i_d,
    input  logic signed [SCORE_W-1:0] i_f,
    input  logic signed [SCORE_W-1:0] i_e,
    input  logic                      i_local,
    output logic signed [SCORE_W-1:0] o_h,
    output logic [1:0]                o_dir
);

    logic signed [SCORE_W-1:0] w_best;
    logic [1:0]                w_dir;

    // Strict compares keep the earlier term on ties.
    always_comb begin
        w_best = i_d;
        w_dir  = DIR_DIAG;
        if (i_f > w_best) begin
            w_best = i_f;
            w_dir  = DIR_UP;
        end
        if (i_e > w_best) begin
            w_best = i_e;
            w_dir  = DIR_LEFT;
        end
        o_h   = w_best;
        o_dir = w_dir;
        if (i_local && (w_best < 0)) begin
            o_h   = '0;
            o_dir = DIR_ZERO;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sw_pe_affine.sv
`default_nettype none
// ============================================================================
// Module   : sw_pe_affine
// Purpose  : One systolic PE computing one affine-gap DP cell per valid target
//            token, with pass-through when no query symbol is loaded.
// Revision : 1.0 - initial release
// ============================================================================
module sw_pe_affine
    import sw_pe_affine_pkg::*;
#(
    parameter int SCORE_W = 16,
    parameter int SYM_W   = 2,
    parameter int ROW_W   = 10,
    parameter int COL_W   = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [SCORE_W-1:0] match_i,
    input  logic signed [SCORE_W-1:0] mismatch_i,
    input  logic signed [SCORE_W-1:0] alpha_i,
    input  logic signed [SCORE_W-1:0] beta_i,
    input  logic                      local_i,
    input  logic                      q_load_i,
    input  logic [SYM_W-1:0]          q_sym_i,
    input  logic [ROW_W-1:0]          q_row_i,
    input  logic signed [SCORE_W-1:0] q_h0_i,
    input  logic                      t_valid_i,
    input  logic                      t_first_i,
    input  logic                      t_last_i,
    input  logic [SYM_W-1:0]          t_sym_i,
    input  logic signed [SCORE_W-1:0] h_in,
    input  logic signed [SCORE_W-1:0] f_in,
    input  logic signed [SCORE_W-1:0] hb_in,
    input  logic signed [SCORE_W-1:0] max_in,
    input  logic [ROW_W-1:0]          max_row_in,
    output logic                      t_valid_o,
    output logic                      t_first_o,
    output logic                      t_last_o,
    output logic [SYM_W-1:0]          t_sym_o,
    output logic signed [SCORE_W-1:0] h_o,
    output logic signed [SCORE_W-1:0] f_o,
    output logic signed [SCORE_W-1:0] hb_o,
    output logic signed [SCORE_W-1:0] max_o,
    output logic [ROW_W-1:0]          max_row_o,
    output logic [COL_W-1:0]          col_o,
    output logic [1:0]                dir_o
);

    localparam logic signed [SCORE_W-1:0] c_neg_inf = SCORE_W'(neg_inf(SCORE_W));

    function automatic logic signed [SCORE_W-1:0] sadd(
        input logic signed [SCORE_W-1:0] a,
        input logic signed [SCORE_W-1:0] b
    );
        return SCORE_W'(sat_add(MAX_W'(a), MAX_W'(b), SCORE_W));
    endfunction

    function automatic logic signed [SCORE_W-1:0] smax(
        input logic signed [SCORE_W-1:0] a,
        input logic signed [SCORE_W-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

    logic [SYM_W-1:0]          r_q_sym;
    logic [ROW_W-1:0]          r_q_row;
    logic signed [SCORE_W-1:0] r_q_h0;
    logic                      r_q_vld;
    logic signed [SCORE_W-1:0] r_h_diag;
    logic signed [SCORE_W-1:0] r_e;
    logic [COL_W-1:0]          r_col;

    logic                      r_tv, r_tf, r_tl;
    logic [SYM_W-1:0]          r_tsym;
    logic signed [SCORE_W-1:0] r_h, r_f, r_hb, r_max;
    logic [ROW_W-1:0]          r_max_row;
    logic [1:0]                r_dir;

    logic signed [SCORE_W-1:0] w_diag, w_hl, w_el, w_s;
    logic signed [SCORE_W-1:0] w_e, w_f, w_d, w_h;
    logic [1:0]                w_dir;
    logic [COL_W-1:0]          w_col_next;

    // Column 0 comes from the boundary inputs rather than the recurrence state.
    assign w_diag = t_first_i ? hb_in     : r_h_diag;
    assign w_hl   = t_first_i ? r_q_h0    : r_h;
    assign w_el   = t_first_i ? c_neg_inf : r_e;
    assign w_s    = (t_sym_i == r_q_sym) ? match_i : mismatch_i;

    assign w_e = smax(sadd(w_hl, alpha_i), sadd(w_el, beta_i));
    assign w_f = smax(sadd(h_in, alpha_i), sadd(f_in, beta_i));
    assign w_d = sadd(w_diag, w_s);

    assign w_col_next = t_first_i ? COL_W'(1) : ((&r_col) ? r_col : r_col + 1'b1);

    sw_max3_dir #(
        .SCORE_W (SCORE_W)
    ) u_max3 (
        .i_d     (w_d),
        .i_f     (w_f),
        .i_e     (w_e),
        .i_local (local_i),
        .o_h     (w_h),
        .o_dir   (w_dir)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_sym   <= '0;
            r_q_row   <= '0;
            r_q_h0    <= '0;
            r_q_vld   <= 1'b0;
            r_h_diag  <= '0;
            r_e       <= c_neg_inf;
            r_col     <= '0;
            r_tv      <= 1'b0;
            r_tf      <= 1'b0;
            r_tl      <= 1'b0;
            r_tsym    <= '0;
            r_h       <= '0;
            r_f       <= '0;
            r_hb      <= '0;
            r_max     <= '0;
            r_max_row <= '0;
            r_dir     <= DIR_ZERO;
        end else begin
            // A token in the load cycle still sees the previous query.
            if (q_load_i) begin
                r_q_sym <= q_sym_i;
                r_q_row <= q_row_i;
                r_q_h0  <= q_h0_i;
                r_q_vld <= 1'b1;
            end
            r_tv <= t_valid_i;
            if (t_valid_i) begin
                r_tf     <= t_first_i;
                r_tl     <= t_last_i;
                r_tsym   <= t_sym_i;
                r_col    <= w_col_next;
                r_h_diag <= h_in;
                if (r_q_vld) begin
                    r_h   <= w_h;
                    r_f   <= w_f;
                    r_e   <= w_e;
                    r_dir <= w_dir;
                    r_hb  <= r_q_h0;
                    if (w_h > max_in) begin
                        r_max     <= w_h;
                        r_max_row <= r_q_row;
                    end else begin
                        r_max     <= max_in;
                        r_max_row <= max_row_in;
                    end
                end else begin
                    r_h       <= h_in;
                    r_f       <= f_in;
                    r_hb      <= hb_in;
                    r_max     <= max_in;
                    r_max_row <= max_row_in;
                    r_dir     <= DIR_ZERO;
                end
            end
        end
    end

    assign t_valid_o = r_tv;
    assign t_first_o = r_tf;
    assign t_last_o  = r_tl;
    assign t_sym_o   = r_tsym;
    assign h_o       = r_h;
    assign f_o       = r_f;
    assign hb_o      = r_hb;
    assign max_o     = r_max;
    assign max_row_o = r_max_row;
    assign col_o     = r_col;
    assign dir_o     = r_dir;

endmodule
`default_nettype wire
